// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   RV32I instruction fetch stage. It holds the PC and keeps at most one
//   request outstanding to instruction memory. The returned word is presented
//   downstream with a valid/stall handshake, and PC redirects from branch/jal/
//   jalr resolution are accepted in every state. A redirect that overtakes an
//   outstanding request marks that response as stale, so it is discarded.
//
//   Build option FETCH_MISALIGN_CHK_EN:
//     defined   - a redirect to a target that is not word aligned is not
//                 taken; instead fetch_misalign pulses for one cycle.
//     undefined - fetch_misalign is tied low, and the redirect target has its
//                 two low bits forced to zero.
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_valid,
    input  logic [31:0]     imem_rdata,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [6:0]      opcode,
    output logic [XLEN-1:0] pc_plus4,
    output logic            fetch_misalign
);

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_VALID,
        S_DROP
    } state_e;

    state_e          state_q;
    logic [XLEN-1:0] pc_q;
    logic [31:0]     instr_q;
    logic [XLEN-1:0] instr_pc_q;
    logic            instr_valid_q;
    logic            misalign_q;

    logic            redirect_take_d;
    logic [XLEN-1:0] redirect_tgt_d;
    logic            misalign_d;

    // Decide whether this cycle's redirect is taken, and where it goes.
    always_comb begin
`ifdef FETCH_MISALIGN_CHK_EN
        misalign_d      = redirect_valid && (redirect_pc[1:0] != 2'b00);
        redirect_take_d = redirect_valid && !misalign_d;
        redirect_tgt_d  = redirect_pc;
`else
        misalign_d      = 1'b0;
        redirect_take_d = redirect_valid;
        redirect_tgt_d  = redirect_pc & ~{{(XLEN-2){1'b0}}, 2'b11};
`endif
    end

    // Fetch FSM together with its registered outputs. A redirect outranks
    // every other transition; a non-taken (misaligned) redirect falls through
    // to normal operation.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: every sequential assignment uses <= so that all registers
        // sample the pre-edge values and the order of statements in this
        // block does not matter.
        if (!rst_n) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= NOP_INSTR;
            instr_pc_q    <= RESET_PC;
            instr_valid_q <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
            if (redirect_take_d) begin
                pc_q          <= redirect_tgt_d;
                instr_valid_q <= 1'b0;
                unique case (state_q)
                    S_IDLE, S_VALID: state_q <= S_REQ;
                    S_REQ:           state_q <= S_DROP;
                    S_WAIT, S_DROP:  state_q <= imem_valid ? S_REQ : S_DROP;
                    default:         state_q <= S_IDLE;
                endcase
            end else begin
                unique case (state_q)
                    S_IDLE: state_q <= S_REQ;
                    S_REQ:  state_q <= S_WAIT;
                    S_WAIT: begin
                        if (imem_valid) begin
                            instr_q       <= imem_rdata;
                            instr_pc_q    <= pc_q;
                            instr_valid_q <= 1'b1;
                            state_q       <= S_VALID;
                        end
                    end
                    S_VALID: begin
                        if (!stall) begin
                            pc_q          <= pc_q + XLEN'(4);
                            instr_valid_q <= 1'b0;
                            state_q       <= S_REQ;
                        end
                    end
                    S_DROP: begin
                        // The stale word is simply not captured.
                        if (imem_valid) begin
                            state_q <= S_REQ;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign imem_req       = (state_q == S_REQ);
    assign imem_addr      = pc_q;
    assign instr_valid    = instr_valid_q;
    assign instr          = instr_q;
    assign instr_pc       = instr_pc_q;
    assign opcode         = instr_q[6:0];
    assign pc_plus4       = instr_pc_q + XLEN'(4);
    assign fetch_misalign = misalign_q;

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//   Self-checking bench for fetch_stage. A behavioural model tracks the fetch
//   in terms of "request issued", "response pending", "response stale" and
//   "instruction held", and every output is compared against it each cycle.
//   Directed scenarios with literal expectations run first, then randomized
//   traffic (memory latency, stall, redirects, a mid-run reset).
// ---------------------------------------------------------------------------
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [6:0]  opcode;
    logic [31:0] pc_plus4;
    logic        fetch_misalign;

    fetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_valid     (imem_valid),
        .imem_rdata     (imem_rdata),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .opcode         (opcode),
        .pc_plus4       (pc_plus4),
        .fetch_misalign (fetch_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic        m_idle;      // first cycle after reset: one bubble before the request
    logic        m_req;       // a request is being issued this cycle
    logic        m_pending;   // a request has been issued and its response not yet seen
    logic        m_stale;     // the pending response must be thrown away
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_ipc;
    logic        m_ivalid;
    logic        m_mis;

    // Memory responder state
    int          mem_cnt;
    int          mem_delay;
    logic [31:0] mem_word;
    bit          rand_mem;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_idle    = 1'b1;
        m_req     = 1'b0;
        m_pending = 1'b0;
        m_stale   = 1'b0;
        m_pc      = 32'h0;
        m_instr   = 32'h0000_0013;
        m_ipc     = 32'h0;
        m_ivalid  = 1'b0;
        m_mis     = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs held across it.
    task automatic model_step();
        logic        resp;
        logic        nxt_pending;
        logic        take;
        logic        bad;
        logic        nxt_req;
        logic [31:0] tgt;
        resp        = imem_valid && m_pending;
        nxt_pending = m_req || (m_pending && !resp);
        bad         = redirect_valid && (redirect_pc[1:0] != 2'b00);
`ifdef FETCH_MISALIGN_CHK_EN
        take  = redirect_valid && !bad;
        tgt   = redirect_pc;
        m_mis = bad;
`else
        take  = redirect_valid;
        tgt   = {redirect_pc[31:2], 2'b00};
        m_mis = 1'b0;
`endif
        if (take) begin
            m_pc     = tgt;
            m_ivalid = 1'b0;
            m_stale  = nxt_pending;
            nxt_req  = !nxt_pending;
        end else begin
            nxt_req = m_idle;
            if (resp) begin
                if (m_stale) begin
                    m_stale = 1'b0;
                    nxt_req = 1'b1;
                end else begin
                    m_instr  = imem_rdata;
                    m_ipc    = m_pc;
                    m_ivalid = 1'b1;
                end
            end else if (m_ivalid && !stall) begin
                m_pc     = m_pc + 32'd4;
                m_ivalid = 1'b0;
                nxt_req  = 1'b1;
            end
        end
        m_idle    = 1'b0;
        m_pending = nxt_pending;
        m_req     = nxt_req;
    endtask

    task automatic compare_all();
        check("imem_req",       {31'b0, imem_req},       {31'b0, m_req});
        check("imem_addr",      imem_addr,               m_pc);
        check("instr_valid",    {31'b0, instr_valid},    {31'b0, m_ivalid});
        check("instr",          instr,                   m_instr);
        check("instr_pc",       instr_pc,                m_ipc);
        check("opcode",         {25'b0, opcode},         {25'b0, m_instr[6:0]});
        check("pc_plus4",       pc_plus4,                m_ipc + 32'd4);
        check("fetch_misalign", {31'b0, fetch_misalign}, {31'b0, m_mis});
    endtask

    // One clock: sample after the edge, check, then drive the memory response.
    task automatic step();
        @(posedge clk);
        #1;
        model_step();
        compare_all();
        imem_valid = 1'b0;
        if (mem_cnt > 0) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                imem_valid = 1'b1;
                imem_rdata = rand_mem ? $urandom : mem_word;
            end
        end
        if (imem_req) mem_cnt = rand_mem ? int'($urandom_range(1, 3)) : mem_delay;
    endtask

    task automatic redirect_to(input logic [31:0] tgt);
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
    endtask

    initial begin
        rst_n          = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_valid     = 1'b0;
        imem_rdata     = 32'h0;
        mem_cnt        = 0;
        mem_delay      = 1;
        mem_word       = 32'h0000_0013;
        rand_mem       = 1'b0;
        model_reset();

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_imem_req",    {31'b0, imem_req},    32'd0);
        check("rst_imem_addr",   imem_addr,            32'h0);
        check("rst_instr",       instr,                32'h0000_0013);
        check("rst_instr_pc",    instr_pc,             32'h0);
        check("rst_misalign",    {31'b0, fetch_misalign}, 32'd0);
        rst_n = 1'b1;

        // 1: NOP stream, 1-cycle memory -> requests at steps 1,4,7; valid at 3,6,9
        for (int s = 1; s <= 9; s++) begin
            step();
            if (s % 3 == 1) begin
                check("s1_req",  {31'b0, imem_req}, 32'd1);
                check("s1_addr", imem_addr, 32'((s / 3) * 4));
            end
            if (s % 3 == 0) begin
                check("s1_valid",   {31'b0, instr_valid}, 32'd1);
                check("s1_opcode",  {25'b0, opcode}, 32'b0010011);
                check("s1_instrpc", instr_pc, 32'((s / 3 - 1) * 4));
            end else begin
                check("s1_novalid", {31'b0, instr_valid}, 32'd0);
            end
        end

        // 2: stall for 4 cycles while holding 32'h00A00093
        mem_word = 32'h00A0_0093;
        repeat (3) step();
        check("s2_instr",   instr,    32'h00A0_0093);
        check("s2_instrpc", instr_pc, 32'd12);
        stall = 1'b1;
        for (int s = 0; s < 4; s++) begin
            step();
            check("s2_hold_valid", {31'b0, instr_valid}, 32'd1);
            check("s2_hold_req",   {31'b0, imem_req},    32'd0);
            check("s2_hold_instr", instr,                32'h00A0_0093);
            check("s2_hold_addr",  imem_addr,            32'd12);
        end
        stall     = 1'b0;
        mem_delay = 3;
        step();
        check("s2_next_req",  {31'b0, imem_req}, 32'd1);
        check("s2_next_addr", imem_addr,         32'd16);

        // 3: redirect during WAIT, stale word returns later and is dropped
        step();
        redirect_to(32'h100);
        mem_word = 32'hDEAD_BEEF;
        step();
        redirect_valid = 1'b0;
        check("s3_drop_valid", {31'b0, instr_valid}, 32'd0);
        check("s3_drop_addr",  imem_addr,            32'h100);
        mem_delay = 1;
        repeat (2) begin
            step();
            check("s3_no_valid", {31'b0, instr_valid}, 32'd0);
            check("s3_kept",     instr,                32'h00A0_0093);
        end
        check("s3_req",  {31'b0, imem_req}, 32'd1);
        check("s3_addr", imem_addr,         32'h100);

        // 4: redirect and response in the same WAIT cycle
        step();
        redirect_to(32'h200);
        step();
        redirect_valid = 1'b0;
        check("s4_no_valid", {31'b0, instr_valid}, 32'd0);
        check("s4_req",      {31'b0, imem_req},    32'd1);
        check("s4_addr",     imem_addr,            32'h200);

        // 6: fetch at the top of the address space, PC wraps to zero
        repeat (2) step();
        redirect_to(32'hFFFF_FFFC);
        step();
        redirect_valid = 1'b0;
        check("s6_addr", imem_addr, 32'hFFFF_FFFC);
        repeat (2) step();
        check("s6_instrpc", instr_pc, 32'hFFFF_FFFC);
        check("s6_plus4",   pc_plus4, 32'h0);
        step();
        check("s6_wrap_req",  {31'b0, imem_req}, 32'd1);
        check("s6_wrap_addr", imem_addr,         32'h0);

        // 5: misaligned redirect from VALID
        repeat (2) step();
        redirect_to(32'h102);
        step();
        redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
        check("s5_misalign", {31'b0, fetch_misalign}, 32'd1);
        check("s5_addr",     imem_addr,               32'h4);
`else
        check("s5_misalign", {31'b0, fetch_misalign}, 32'd0);
        check("s5_addr",     imem_addr,               32'h100);
`endif
        step();
        check("s5_pulse_end", {31'b0, fetch_misalign}, 32'd0);

        // Randomized traffic, with one asynchronous reset in the middle
        rand_mem = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            stall          = ($urandom_range(0, 9) < 4);
            redirect_valid = ($urandom_range(0, 99) < 8);
            redirect_pc    = $urandom;
            if ($urandom_range(0, 3) != 0) redirect_pc[1:0] = 2'b00;
            if (i == 1500) begin
                #2;
                rst_n = 1'b0;
                #1;
                model_reset();
                compare_all();
                @(posedge clk);
                #1;
                compare_all();
                rst_n = 1'b1;
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
